htif_tohost_monitor: RTL and testbench
======================================

# htif_tohost_monitor

Parametrised host-interface monitor that sits between NHART instruction-set-simulator harts and the testbench top. It gathers every hart's `tohost` writes and decodes riscv-tests exit writes into per-hart done, pass and exit-code status. Non-exit writes, such as console and syscall traffic, go through per-hart holding registers and a round-robin arbiter into one shared FIFO that the host drains. An optional watchdog flags simulations that never finish.

## Interface
Parameters:
- NHART, 2, number of harts; legal range 1..16.
- DEPTH, 8, shared FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 1000000, watchdog limit. Used only when HTIF_TIMEOUT_EN is defined.
- HW, $clog2(NHART) with a minimum of 1, width of the hart-ID field.

Ports:
- CLK  in  1  clock.
- RSTn  in  1  reset, asynchronous, active-low.
- tohost_we  in  NHART  per-hart write strobe, one cycle per write.
- tohost  in  NHART*32  per-hart write data; hart h uses bits [32h+31:32h].
- tohost_busy  out  NHART  hart h must not issue a non-exit write while its bit is 1.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  host accepts the head.
- out_hart  out  HW  hart ID of the head entry.
- out_data  out  32  tohost value of the head entry.
- done  out  NHART  hart h has written an exit value.
- exit_code  out  NHART*31  per-hart value of tohost[31:1] from its exit write.
- all_done  out  1  all bits of done are 1.
- pass_all  out  1  all_done is 1 and every exit_code is 0.
- err_drop  out  1  sticky; a write was discarded.
- timeout  out  1  sticky watchdog flag. Tied to 0 without HTIF_TIMEOUT_EN.

## Operation
- Write classification: bit 0 = 1 means an exit write; bit 0 = 0 means a non-exit write.
- Exit write from hart h with done[h] = 0:
  - done[h] is set to 1.
  - exit_code[h] is loaded with tohost[31:1].
  - The holding register is not used, so the write is accepted even when busy[h] = 1.
- Any write from hart h with done[h] = 1 is ignored. It sets err_drop only if it was a non-exit write.
- Non-exit write from hart h:
  - Loads hold[h] and sets hold_valid[h].
  - If busy[h] = 1 at that moment, the write is discarded, hold[h] is left unchanged, and err_drop is set.
- Arbiter:
  - Eligible when count < DEPTH.
  - Grants exactly one hart with hold_valid = 1, searching round-robin from last_grant+1 and wrapping modulo NHART.
  - The granted entry {h, hold[h]} is pushed into the FIFO; hold_valid[h] is cleared and last_grant is set to h.
- tohost_busy[h] = hold_valid[h] && !grant[h], combinational. A hart can therefore write again in the same cycle its entry is granted.
- FIFO:
  - Pop occurs when out_valid && out_ready.
  - Push and pop may happen in the same cycle. Push is gated only on count < DEPTH as seen before the pop, so a full FIFO does not accept a push even while popping.
  - Pointers wrap modulo DEPTH.
- out_valid = (count != 0). out_hart and out_data always reflect the head entry, show-ahead.
- Reset values: done 0, exit_code 0, hold_valid 0, last_grant NHART-1 (hart 0 has first priority), count 0, out_valid 0, out_hart 0, out_data 0, err_drop 0, timeout 0, tohost_busy 0.
- Reset asserted mid-operation immediately clears all state and discards FIFO contents.

## Timing
- Exit write sampled at edge t: done and exit_code are valid after edge t. all_done and pass_all are combinational from those registers.
- Non-exit write sampled at edge t:
  - hold_valid is set after edge t.
  - With no contention, the push occurs at edge t+1 and out_valid = 1 after edge t+1.
  - Minimum latency is 2 edges.
- Worst-case wait for a held write is NHART-1 grant cycles, plus any cycles spent with the FIFO full.
- Throughput: one push and one pop per cycle.

## Configuration
- HTIF_TIMEOUT_EN defined:
  - A 32-bit cycle counter increments every cycle while all_done = 0 and timeout = 0.
  - When the counter equals TIMEOUT_CYCLES-1, timeout is set to 1 and stays set.
  - The counter freezes once all_done = 1.
- HTIF_TIMEOUT_EN undefined: no counter logic is built and timeout is constant 0.

## Test plan
- Exit codes: NHART=2; hart0 writes 0x1 and hart1 writes 0x7 in the same cycle.
  - Required: done = 2'b11 one edge later, exit_code[1] = 3, all_done = 1, pass_all = 0.
- Console ordering: hart0 writes 0x100 at t with out_ready = 1.
  - Required: out_valid at t+2 with out_hart = 0 and out_data = 0x100; pops one cycle later.
- Contention: both harts write non-exit values every cycle with out_ready = 1.
  - Required: output alternates hart0/hart1, tohost_busy never lets a write be dropped, err_drop stays 0.
- FIFO full: DEPTH=4, out_ready = 0, 5 writes from hart0 honouring busy.
  - Required: count stays at 4, tohost_busy[0] is held at 1.
  - Then out_ready = 1: all 5 values drain in order.
- Errors and reset: a write while busy sets err_drop; a write after done is ignored.
  - Asserting RSTn low with the FIFO partially full must clear out_valid, done and err_drop asynchronously.
- Watchdog: with HTIF_TIMEOUT_EN and TIMEOUT_CYCLES = 50, no exit write is issued.
  - Required: timeout rises after edge 50 and stays set.
  - Without the macro, timeout stays 0.

Source files
------------

// File: rtl/htif_tohost_monitor.sv
// htif_tohost_monitor: decodes per-hart tohost exit writes and funnels console writes through a round-robin arbiter into a shared FIFO.
// Optional watchdog built when HTIF_TIMEOUT_EN is defined.
module htif_tohost_monitor #(
  parameter int NHART = 2,
  parameter int DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int HW = (NHART > 1) ? $clog2(NHART) : 1
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [NHART-1:0]    tohost_we,
  input  logic [NHART*32-1:0] tohost,
  output logic [NHART-1:0]    tohost_busy,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [HW-1:0]       out_hart,
  output logic [31:0]         out_data,
  output logic [NHART-1:0]    done,
  output logic [NHART*31-1:0] exit_code,
  output logic                all_done,
  output logic                pass_all,
  output logic                err_drop,
  output logic                timeout
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [NHART-1:0] done_q, hv_q, grant;
  logic [30:0]      code_q [NHART];
  logic [31:0]      hold_q [NHART];
  logic [HW+31:0]   mem_q [DEPTH];
  logic [HW-1:0]    last_q, gidx;
  logic [PW-1:0]    wp_q, rp_q;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, push, pop;
  // Round-robin search starts just after the last granted hart.
  always_comb begin
    grant = '0;
    gidx = '0;
    push = 1'b0;
    for (int i = 1; i <= NHART; i++) begin
      int idx;
      idx = (int'(last_q) + i) % NHART;
      if (!push && hv_q[idx] && count_q < CW'(DEPTH)) begin
        grant[idx] = 1'b1;
        gidx = HW'(idx);
        push = 1'b1;
      end
    end
  end
  assign pop = (count_q != '0) && out_ready;
  assign count_d = count_q + CW'(push) - CW'(pop);
  assign tohost_busy = hv_q & ~grant;
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      done_q <= '0;
      hv_q <= '0;
      last_q <= HW'(NHART - 1);
      err_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
      for (int h = 0; h < NHART; h++) begin
        code_q[h] <= '0;
        hold_q[h] <= '0;
      end
      for (int d = 0; d < DEPTH; d++) mem_q[d] <= '0;
    end else begin
      for (int h = 0; h < NHART; h++) begin
        if (grant[h]) hv_q[h] <= 1'b0;
        if (tohost_we[h]) begin
          if (done_q[h]) begin
            if (!tohost[32*h]) err_q <= 1'b1;
          end else if (tohost[32*h]) begin
            done_q[h] <= 1'b1;
            code_q[h] <= tohost[32*h+1 +: 31];
          end else if (tohost_busy[h]) begin
            err_q <= 1'b1;
          end else begin
            hold_q[h] <= tohost[32*h +: 32];
            hv_q[h] <= 1'b1;
          end
        end
      end
      if (push) begin
        mem_q[wp_q] <= {gidx, hold_q[gidx]};
        wp_q <= wp_q + 1'b1;
        last_q <= gidx;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      count_q <= count_d;
    end
  end
  for (genvar g = 0; g < NHART; g++) begin : g_code
    assign exit_code[31*g +: 31] = code_q[g];
  end
  assign out_valid = count_q != '0;
  assign out_hart = mem_q[rp_q][HW+31:32];
  assign out_data = mem_q[rp_q][31:0];
  assign done = done_q;
  assign all_done = &done_q;
  assign pass_all = all_done && (exit_code == '0);
  assign err_drop = err_q;
`ifdef HTIF_TIMEOUT_EN
  logic [31:0] cyc_q;
  logic        to_q;
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cyc_q <= '0;
      to_q <= 1'b0;
    end else if (!all_done && !to_q) begin
      cyc_q <= cyc_q + 1'b1;
      if (cyc_q == 32'(TIMEOUT_CYCLES - 1)) to_q <= 1'b1;
    end
  end
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_htif_tohost_monitor.sv
// tb_htif_tohost_monitor: directed stimulus with a queue scoreboard drained by an independent FIFO monitor.
module tb_htif_tohost_monitor;
  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [1:0]  tohost_we = '0;
  logic [63:0] tohost = '0;
  logic [1:0]  tohost_busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [0:0]  out_hart;
  logic [31:0] out_data;
  logic [1:0]  done;
  logic [61:0] exit_code;
  logic        all_done, pass_all, err_drop, timeout;
  int          nchk = 0;
  int          nerr = 0;
  logic [32:0] sb [$];
  localparam logic TO_EXP =
`ifdef HTIF_TIMEOUT_EN
    1'b1;
`else
    1'b0;
`endif
  always #5 CLK = ~CLK;
  htif_tohost_monitor #(.NHART(2), .DEPTH(4), .TIMEOUT_CYCLES(50)) dut (
    .CLK(CLK), .RSTn(RSTn), .tohost_we(tohost_we), .tohost(tohost),
    .tohost_busy(tohost_busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_hart(out_hart), .out_data(out_data), .done(done), .exit_code(exit_code),
    .all_done(all_done), .pass_all(pass_all), .err_drop(err_drop), .timeout(timeout)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic wr(input int h, input logic [31:0] d);
    tohost_we = '0;
    tohost_we[h] = 1'b1;
    tohost[32*h +: 32] = d;
    @(negedge CLK);
    tohost_we = '0;
  endtask
  task automatic fill0(input logic [31:0] base);
    int n = 0;
    for (int c = 0; c < 30 && n < 5; c++) begin
      if (!tohost_busy[0]) begin
        sb.push_back({1'b0, base + 32'(n * 4)});
        wr(0, base + 32'(n * 4));
        n++;
      end else @(negedge CLK);
    end
    check("fill_writes", 64'(n), 64'd5);
  endtask
  task automatic drain(input string name);
    for (int c = 0; c < 40 && sb.size() != 0; c++) @(negedge CLK);
    check(name, 64'(sb.size()), 64'd0);
  endtask
  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge CLK);
      #1;
      if (RSTn && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL fifo_extra: got hart %0d data 0x%0h expected no entry", out_hart, out_data);
        end else begin
          e = sb.pop_front();
          check("fifo_head", 64'({out_hart, out_data}), 64'(e));
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
  initial begin : stim
    int i0, i1;
    repeat (2) @(negedge CLK);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(tohost_busy), 64'd0);
    check("rst_err", 64'(err_drop), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_head", 64'({out_hart, out_data}), 64'd0);
    check("rst_all_done", 64'(all_done), 64'd0);
    RSTn = 1'b1;
    @(negedge CLK);
    // console write: held after edge t, visible after edge t+1, popped after t+2
    out_ready = 1'b1;
    tohost_we = 2'b01;
    tohost[31:0] = 32'h100;
    sb.push_back({1'b0, 32'h100});
    @(posedge CLK); #1;
    check("console_t", 64'(out_valid), 64'd0);
    @(negedge CLK);
    tohost_we = '0;
    @(posedge CLK); #1;
    check("console_t1_valid", 64'(out_valid), 64'd1);
    check("console_t1_head", 64'({out_hart, out_data}), 64'h100);
    @(posedge CLK); #1;
    check("console_popped", 64'(out_valid), 64'd0);
    @(negedge CLK);
    // contention: hart 0 was granted last, so hart 1 leads the alternation
    for (int k = 0; k < 6; k++) begin
      sb.push_back({1'b1, 32'h2000 + 32'(k * 4)});
      sb.push_back({1'b0, 32'h1000 + 32'(k * 4)});
    end
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 40 && (i0 < 6 || i1 < 6); c++) begin
      tohost_we = '0;
      if (!tohost_busy[0] && i0 < 6) begin
        tohost_we[0] = 1'b1;
        tohost[31:0] = 32'h1000 + 32'(i0 * 4);
        i0++;
      end
      if (!tohost_busy[1] && i1 < 6) begin
        tohost_we[1] = 1'b1;
        tohost[63:32] = 32'h2000 + 32'(i1 * 4);
        i1++;
      end
      @(negedge CLK);
    end
    tohost_we = '0;
    drain("contention_drain");
    check("contention_err", 64'(err_drop), 64'd0);
    // FIFO full then drain in order
    out_ready = 1'b0;
    fill0(32'h3000);
    repeat (3) @(negedge CLK);
    check("full_count", 64'(dut.count_q), 64'd4);
    check("full_busy", 64'(tohost_busy[0]), 64'd1);
    check("full_head", 64'(out_data), 64'h3000);
    out_ready = 1'b1;
    drain("full_drain");
    check("full_empty", 64'(out_valid), 64'd0);
    // drop while busy, then exit writes accepted despite busy
    out_ready = 1'b0;
    fill0(32'h4000);
    @(negedge CLK);
    check("drop_busy", 64'(tohost_busy[0]), 64'd1);
    wr(0, 32'h666);
    check("drop_err", 64'(err_drop), 64'd1);
    tohost_we = 2'b11;
    tohost = {32'h7, 32'h1};
    @(negedge CLK);
    tohost_we = '0;
    check("exit_done", 64'(done), 64'd3);
    check("exit_code1", 64'(exit_code[61:31]), 64'd3);
    check("exit_code0", 64'(exit_code[30:0]), 64'd0);
    check("exit_all_done", 64'(all_done), 64'd1);
    check("exit_pass_all", 64'(pass_all), 64'd0);
    check("exit_head_kept", 64'(out_data), 64'h4000);
    // asynchronous reset with FIFO full
    #2;
    RSTn = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_err", 64'(err_drop), 64'd0);
    check("arst_busy", 64'(tohost_busy), 64'd0);
    check("arst_code", 64'(exit_code), 64'd0);
    check("arst_timeout", 64'(timeout), 64'd0);
    sb.delete();
    @(negedge CLK);
    RSTn = 1'b1;
    // watchdog counts edges from reset release
    repeat (49) @(posedge CLK);
    #1;
    check("timeout_49", 64'(timeout), 64'd0);
    @(posedge CLK); #1;
    check("timeout_50", 64'(timeout), 64'(TO_EXP));
    repeat (10) @(posedge CLK);
    #1;
    check("timeout_hold", 64'(timeout), 64'(TO_EXP));
    @(negedge CLK);
    // writes after done are ignored
    out_ready = 1'b1;
    wr(0, 32'h1);
    check("pass0_done", 64'(done), 64'd1);
    check("pass0_all_done", 64'(all_done), 64'd0);
    check("pass0_pass_all", 64'(pass_all), 64'd0);
    wr(0, 32'h3);
    check("late_exit_code", 64'(exit_code[30:0]), 64'd0);
    check("late_exit_err", 64'(err_drop), 64'd0);
    wr(0, 32'h500);
    check("late_console_err", 64'(err_drop), 64'd1);
    repeat (3) @(negedge CLK);
    check("late_console_valid", 64'(out_valid), 64'd0);
    check("late_console_busy", 64'(tohost_busy), 64'd0);
    wr(1, 32'h1);
    check("pass_done", 64'(done), 64'd3);
    check("pass_all_done", 64'(all_done), 64'd1);
    check("pass_all", 64'(pass_all), 64'd1);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
